// File: rtl/disp_pkg.sv
// Shared constants for the 7-segment scan driver: segment codes (a..g, active-low)
// and the hex-to-segment decode.
package disp_pkg;

    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_2     = 7'b0010010;
    localparam logic [0:6] SEG_3     = 7'b0000110;
    localparam logic [0:6] SEG_4     = 7'b1001100;
    localparam logic [0:6] SEG_5     = 7'b0100100;
    localparam logic [0:6] SEG_6     = 7'b0100000;
    localparam logic [0:6] SEG_7     = 7'b0001111;
    localparam logic [0:6] SEG_8     = 7'b0000000;
    localparam logic [0:6] SEG_9     = 7'b0000100;
    localparam logic [0:6] SEG_A     = 7'b0001000;
    localparam logic [0:6] SEG_B     = 7'b1100000;
    localparam logic [0:6] SEG_C     = 7'b0110001;
    localparam logic [0:6] SEG_D     = 7'b1000010;
    localparam logic [0:6] SEG_E     = 7'b0110000;
    localparam logic [0:6] SEG_F     = 7'b0111000;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    // Pins are active-low: segments, decimal point and anodes alike.
    localparam logic SEG_ON  = 1'b0;
    localparam logic SEG_OFF = 1'b1;
    localparam logic AN_ON   = 1'b0;
    localparam logic AN_OFF  = 1'b1;

    function automatic logic [0:6] hex2seg(input logic [3:0] h);
        logic [0:6] s;
        case (h)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = SEG_A;
            4'hB: s = SEG_B;
            4'hC: s = SEG_C;
            4'hD: s = SEG_D;
            4'hE: s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Refresh prescaler: free-running 0..SCAN_DIV-1 counter, tick high on the last count.
module scan_tick_gen #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/hex_display_scan.sv
// Time-multiplexed N-digit common-anode 7-segment driver with shadowed hex word,
// decimal points, leading-zero blanking and per-digit blink.
module hex_display_scan
    import disp_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] value_in,
    input  logic                  load,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic                  blank_lz,
    output logic [0:6]            seg_out,
    output logic                  dp_out,
    output logic [N_DIGITS-1:0]   an_out
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic                         tick;
    logic [N_DIGITS-1:0][3:0]     value_sh;
    logic [N_DIGITS-1:0]          dp_sh;
    logic [N_DIGITS-1:0]          blink_sh;
    logic [IDX_W-1:0]             idx;
    logic [FRM_W-1:0]             frame_cnt;
    logic                         blink_phase;
    logic                         frame_end;

    logic [N_DIGITS:1]            zero_from;
    logic [N_DIGITS-1:0]          lz_vec;
    logic                         blank_d;
    logic [0:6]                   seg_d;
    logic                         dp_d;
    logic [N_DIGITS-1:0]          an_d;

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // zero_from[i]: shadow digits N_DIGITS-1 down to i are all zero.
    assign zero_from[N_DIGITS] = 1'b1;
    assign lz_vec[0]           = 1'b0;
    for (genvar g = 1; g < N_DIGITS; g++) begin : g_lz
        assign zero_from[g] = (value_sh[g] == 4'h0) && zero_from[g+1];
        assign lz_vec[g]    = zero_from[g];
    end

    assign frame_end = tick && (idx == IDX_LAST);

    always_comb begin
        blank_d = (blank_lz && lz_vec[idx]) || (blink_sh[idx] && blink_phase);
        seg_d   = hex2seg(value_sh[idx]);
        dp_d    = ~dp_sh[idx];
        an_d    = ~(N_DIGITS'(1) << idx);
        if (blank_d) begin
            seg_d = SEG_BLANK;
            dp_d  = SEG_OFF;
        end
    end

    // Shadow capture; a load coinciding with a tick still lets that tick use the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_sh <= '0;
            dp_sh    <= '0;
            blink_sh <= '0;
        end else if (load) begin
            value_sh <= value_in;
            dp_sh    <= dp_in;
            blink_sh <= blink_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (tick)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (frame_end) begin
                if (frame_cnt == FRM_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out <= SEG_BLANK;
            dp_out  <= SEG_OFF;
            an_out  <= {N_DIGITS{AN_OFF}};
        end else if (tick) begin
            seg_out <= seg_d;
            dp_out  <= dp_d;
            an_out  <= an_d;
        end
    end

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan (4 digits, SCAN_DIV=4, BLINK_FRAMES=2) with an
// expected-drive queue popped at each refresh update.
module tb_hex_display_scan;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int BF = 2;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0111000;
    localparam logic [6:0] SB = 7'b1111111;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [4*N-1:0] value_in = '0;
    logic           load = 1'b0;
    logic [N-1:0]   dp_in = '0;
    logic [N-1:0]   blink_mask = '0;
    logic           blank_lz = 1'b0;
    logic [0:6]     seg_out;
    logic           dp_out;
    logic [N-1:0]   an_out;

    int checks = 0;
    int errors = 0;
    int pc;

    typedef struct {
        string      tag;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;
    exp_t q[$];

    hex_display_scan #(.N_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .load       (load),
        .dp_in      (dp_in),
        .blink_mask (blink_mask),
        .blank_lz   (blank_lz),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .an_out     (an_out)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; drive updates land on multiples of SD.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 0;
        else        pc <= pc + 1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] an, input logic [6:0] seg,
                             input logic dp);
        chk({tag, "_an"},  {4'b0, an_out},  {4'b0, an});
        chk({tag, "_seg"}, {1'b0, seg_out}, {1'b0, seg});
        chk({tag, "_dp"},  {7'b0, dp_out},  {7'b0, dp});
    endtask

    task automatic push(input string tag, input logic [3:0] an, input logic [6:0] seg,
                        input logic dp);
        exp_t e;
        e.tag = tag; e.an = an; e.seg = seg; e.dp = dp;
        q.push_back(e);
    endtask

    task automatic next_tick();
        exp_t e;
        bit found;
        found = 1'b0;
        for (int k = 0; k < 2 * SD; k++) begin
            @(posedge clk); #1;
            if (pc % SD == 0) begin
                found = 1'b1;
                break;
            end
        end
        chk("tick_seen", {7'b0, found}, 8'd1);
        chk("queue_nonempty", {7'b0, q.size() != 0}, 8'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
            check_out(e.tag, e.an, e.seg, e.dp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        load  = 1'b0;
        #1;
        check_out("rst_async", 4'b1111, SB, 1'b1);
        @(posedge clk); #1;
        check_out("rst_hold", 4'b1111, SB, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_word(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bm,
                             input logic lz);
        @(negedge clk);
        value_in = v; dp_in = dp; blink_mask = bm; blank_lz = lz; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Reset state and first-tick latency (shadow is zero after reset).
        repeat (2) @(posedge clk);
        do_reset();
        for (int k = 1; k < SD; k++) begin
            @(posedge clk); #1;
            check_out("pre_tick", 4'b1111, SB, 1'b1);
        end
        push("first_tick", 4'b1110, S0, 1'b1);
        next_tick();

        // Basic scan, no blanking.
        do_reset();
        load_word(16'h12AF, 4'b0000, 4'b0000, 1'b0);
        push("scan_d0", 4'b1110, SF, 1'b1);
        push("scan_d1", 4'b1101, SA, 1'b1);
        push("scan_d2", 4'b1011, S2, 1'b1);
        push("scan_d3", 4'b0111, S1, 1'b1);
        push("scan_wrap", 4'b1110, SF, 1'b1);
        repeat (5) next_tick();

        // Leading-zero blanking.
        do_reset();
        load_word(16'h0050, 4'b0000, 4'b0000, 1'b1);
        push("lz_d0", 4'b1110, S0, 1'b1);
        push("lz_d1", 4'b1101, S5, 1'b1);
        push("lz_d2", 4'b1011, SB, 1'b1);
        push("lz_d3", 4'b0111, SB, 1'b1);
        repeat (4) next_tick();
        load_word(16'h0000, 4'b0000, 4'b0000, 1'b1);
        push("lz0_d0", 4'b1110, S0, 1'b1);
        push("lz0_d1", 4'b1101, SB, 1'b1);
        push("lz0_d2", 4'b1011, SB, 1'b1);
        push("lz0_d3", 4'b0111, SB, 1'b1);
        repeat (4) next_tick();

        // Decimal point and blink: digit 0 lit two frames, blank two frames.
        do_reset();
        load_word(16'h8888, 4'b0100, 4'b0001, 1'b0);
        for (int f = 0; f < 5; f++) begin
            push($sformatf("blk_f%0d_d0", f), 4'b1110, ((f / 2) % 2 == 1) ? SB : S8, 1'b1);
            push($sformatf("blk_f%0d_d1", f), 4'b1101, S8, 1'b1);
            push($sformatf("blk_f%0d_d2", f), 4'b1011, S8, 1'b0);
            push($sformatf("blk_f%0d_d3", f), 4'b0111, S8, 1'b1);
        end
        repeat (20) next_tick();

        // Load on the same edge as the digit-1 tick.
        do_reset();
        load_word(16'h1234, 4'b0000, 4'b0000, 1'b0);
        push("col_d0", 4'b1110, S4, 1'b1);
        next_tick();
        repeat (SD - 1) @(posedge clk);
        @(negedge clk);
        value_in = 16'hFFFF;
        load = 1'b1;
        push("col_d1_old", 4'b1101, S3, 1'b1);
        next_tick();
        @(negedge clk);
        load = 1'b0;
        push("col_d2", 4'b1011, SF, 1'b1);
        push("col_d3", 4'b0111, SF, 1'b1);
        push("col_d0_new", 4'b1110, SF, 1'b1);
        push("col_d1_new", 4'b1101, SF, 1'b1);
        repeat (4) next_tick();

        // Asynchronous reset while digit 2 is next; shadow clears to zero.
        do_reset();
        load_word(16'h1234, 4'b0000, 4'b0000, 1'b0);
        push("mid_d0", 4'b1110, S4, 1'b1);
        push("mid_d1", 4'b1101, S3, 1'b1);
        repeat (2) next_tick();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_out("mid_rst", 4'b1111, SB, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k < SD; k++) begin
            @(posedge clk); #1;
            check_out("mid_pre_tick", 4'b1111, SB, 1'b1);
        end
        push("mid_restart", 4'b1110, S0, 1'b1);
        next_tick();

        chk("queue_drained", 8'(q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
